// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one combinational barrel shifter between two requesters. Each
//   requester sends an operation on a request channel and collects the result
//   on a response channel. Operands and results are registered, so the
//   requesters never see the shifter's combinational path.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both high. The requester keeps valid and payload stable until
//   then. reqN_ready is high only in IDLE and only for the requester being
//   granted. respN_valid is high only in RESP and only for the owner.
//
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   reqN_valid / reqN_ready         request handshake (N = 0, 1)
//   reqN_in, reqN_shamt             operand and shift amount (0..31)
//   reqN_dir                        1 = left, 0 = right
//   reqN_aorl                       1 = arithmetic right, 0 = logical
//   respN_valid / respN_ready       response handshake
//   respN_data                      result register
//   busy                            high in any state other than IDLE
//   dbg_state                       FSM state (IDLE=0, EXEC=1, RESP=2)
//   dbg_prio                        round-robin priority pointer
// -----------------------------------------------------------------------------

// Combinational barrel shifter. The shift amount arrives zero-extended to the
// full datapath width.
module barrel_shifter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] shamt,
  input  logic             dir,
  input  logic             aorl,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    if (dir) begin
      out = in << shamt;
    end else if (aorl) begin
      out = $unsigned($signed(in) >>> shamt);
    end else begin
      out = in >> shamt;
    end
  end
endmodule

module shift_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in,
  input  logic [4:0]       req0_shamt,
  input  logic             req0_dir,
  input  logic             req0_aorl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in,
  input  logic [4:0]       req1_shamt,
  input  logic             req1_dir,
  input  logic             req1_aorl,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_data,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_data,
  output logic             busy,
  output logic [1:0]       dbg_state,
  output logic             dbg_prio
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op_in_q, op_in_d;
  logic [4:0]       op_shamt_q, op_shamt_d;
  logic             op_dir_q, op_dir_d;
  logic             op_aorl_q, op_aorl_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             grant0, grant1;
  logic [WIDTH-1:0] shift_out;

  barrel_shifter #(.WIDTH(WIDTH)) u_shifter (
    .in    (op_in_q),
    .shamt ({{(WIDTH-5){1'b0}}, op_shamt_q}),
    .dir   (op_dir_q),
    .aorl  (op_aorl_q),
    .out   (shift_out)
  );

  // A lone requester always wins; under contention prio picks the winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      grant0 = req0_valid && (!req1_valid || !prio_q);
      grant1 = req1_valid && (!req0_valid ||  prio_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    op_in_d    = op_in_q;
    op_shamt_d = op_shamt_q;
    op_dir_d   = op_dir_q;
    op_aorl_d  = op_aorl_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          owner_d    = 1'b0;
          op_in_d    = req0_in;
          op_shamt_d = req0_shamt;
          op_dir_d   = req0_dir;
          op_aorl_d  = req0_aorl;
          prio_d     = 1'b1;
          state_d    = EXEC;
        end else if (grant1) begin
          owner_d    = 1'b1;
          op_in_d    = req1_in;
          op_shamt_d = req1_shamt;
          op_dir_d   = req1_dir;
          op_aorl_d  = req1_aorl;
          prio_d     = 1'b0;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d = shift_out;
        state_d  = RESP;
      end
      RESP: begin
        if ((owner_q == 1'b0 && resp0_ready) || (owner_q == 1'b1 && resp1_ready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      op_in_q    <= '0;
      op_shamt_q <= '0;
      op_dir_q   <= 1'b0;
      op_aorl_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      op_in_q    <= op_in_d;
      op_shamt_q <= op_shamt_d;
      op_dir_q   <= op_dir_d;
      op_aorl_q  <= op_aorl_d;
      result_q   <= result_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign resp0_valid = (state_q == RESP) && (owner_q == 1'b0);
  assign resp1_valid = (state_q == RESP) && (owner_q == 1'b1);
  assign resp0_data  = result_q;
  assign resp1_data  = result_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;
  assign dbg_prio    = prio_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_in, req1_in;
  logic [4:0]   req0_shamt, req1_shamt;
  logic         req0_dir, req1_dir;
  logic         req0_aorl, req1_aorl;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready, resp1_ready;
  logic [W-1:0] resp0_data, resp1_data;
  logic         busy;
  logic [1:0]   dbg_state;
  logic         dbg_prio;

  shift_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
    .req0_shamt(req0_shamt), .req0_dir(req0_dir), .req0_aorl(req0_aorl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
    .req1_shamt(req1_shamt), .req1_dir(req1_dir), .req1_aorl(req1_aorl),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .busy(busy), .dbg_state(dbg_state), .dbg_prio(dbg_prio)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: an accepted operation produces its result
  // two cycles after acceptance and is then offered until taken.
  logic         m_busy;
  int           m_age;
  logic         m_owner;
  logic         m_prio;
  logic [W-1:0] m_data;
  logic [W-1:0] exp_q[$];
  int           hs;
  logic         took;
  logic [W-1:0] took_data;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [4:0] sh,
                                             input logic dir, input logic aorl);
    longint unsigned p;
    longint unsigned x;
    p = 1;
    for (int i = 0; i < int'(sh); i++) p = p * 2;
    x = {32'd0, a};
    if (dir) return W'((x * p) % 64'h1_0000_0000);
    if (aorl && a[W-1]) return ~W'((64'hFFFF_FFFF - x) / p);
    return W'(x / p);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_owner = 1'b0; m_prio = 1'b0; m_data = '0;
    exp_q.delete();
  endtask

  // One clock cycle: inputs were set by the caller; check outputs, advance model.
  task automatic cycle();
    int  g;
    logic ev0, ev1;
    #1;
    hs = -1; took = 1'b0;
    if (rst) begin
      check_val("rst_ready0", W'(req0_ready), 0);
      check_val("rst_ready1", W'(req1_ready), 0);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      return;
    end
    g = -1;
    if (!m_busy) begin
      if (req0_valid && (!req1_valid || !m_prio)) g = 0;
      else if (req1_valid) g = 1;
    end
    ev0 = m_busy && m_age == 1 && m_owner == 1'b0;
    ev1 = m_busy && m_age == 1 && m_owner == 1'b1;
    check_val("req0_ready", W'(req0_ready), W'(g == 0));
    check_val("req1_ready", W'(req1_ready), W'(g == 1));
    check_val("resp0_valid", W'(resp0_valid), W'(ev0));
    check_val("resp1_valid", W'(resp1_valid), W'(ev1));
    check_val("busy", W'(busy), W'(m_busy));
    check_val("prio", W'(dbg_prio), W'(m_prio));
    if (ev0) check_val("resp0_data", resp0_data, m_data);
    if (ev1) check_val("resp1_data", resp1_data, m_data);
    if (!m_busy) begin
      check_val("idle_data0", resp0_data, m_data);
      check_val("idle_data1", resp1_data, m_data);
    end
    if (g == 0) begin
      exp_q.push_back(ref_shift(req0_in, req0_shamt, req0_dir, req0_aorl));
      m_busy = 1'b1; m_age = 0; m_owner = 1'b0; m_prio = 1'b1; hs = 0;
    end else if (g == 1) begin
      exp_q.push_back(ref_shift(req1_in, req1_shamt, req1_dir, req1_aorl));
      m_busy = 1'b1; m_age = 0; m_owner = 1'b1; m_prio = 1'b0; hs = 1;
    end else if (m_busy && m_age == 0) begin
      m_age = 1;
      m_data = exp_q.pop_front();
    end else if (m_busy && ((ev0 && resp0_ready) || (ev1 && resp1_ready))) begin
      m_busy = 1'b0;
      took = 1'b1;
      took_data = ev0 ? resp0_data : resp1_data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                         input logic [4:0] sh, input logic dir, input logic aorl);
    if (i == 0) begin
      req0_valid = v; req0_in = a; req0_shamt = sh; req0_dir = dir; req0_aorl = aorl;
    end else begin
      req1_valid = v; req1_in = a; req1_shamt = sh; req1_dir = dir; req1_aorl = aorl;
    end
  endtask

  task automatic drop_req(input int i);
    if (i == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Issue one op, wait for its response to be taken, compare to a constant.
  task automatic run_op(input string tag, input int i, input logic [W-1:0] a,
                        input logic [4:0] sh, input logic dir, input logic aorl,
                        input logic [W-1:0] exp);
    int n;
    set_req(i, 1'b1, a, sh, dir, aorl);
    n = 0;
    do begin cycle(); n++; end while (hs != i && n < 40);
    drop_req(i);
    if (hs != i) check_val({tag, "_grant_timeout"}, 1, 0);
    n = 0;
    do begin cycle(); n++; end while (!took && n < 40);
    if (!took) check_val({tag, "_resp_timeout"}, 1, 0);
    else check_val(tag, took_data, exp);
  endtask

  initial begin : stim
    int n;
    logic [W-1:0] held;
    rst = 1'b1;
    req0_valid = 0; req0_in = 0; req0_shamt = 0; req0_dir = 0; req0_aorl = 0;
    req1_valid = 0; req1_in = 0; req1_shamt = 0; req1_dir = 0; req1_aorl = 0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(); cycle();
    rst = 1'b0;
    cycle();  // reset state: idle, prio 0, data 0

    // directed vectors
    run_op("left_4567", 0, 32'd4567, 5'd4, 1'b1, 1'b0, 32'd73072);
    run_op("sra_m64", 1, 32'hFFFFFFC0, 5'd4, 1'b0, 1'b1, 32'hFFFFFFFC);
    run_op("srl_m64", 1, 32'hFFFFFFC0, 5'd4, 1'b0, 1'b0, 32'h0FFFFFFC);
    run_op("sll_m64", 1, 32'hFFFFFFC0, 5'd4, 1'b1, 1'b1, 32'hFFFFFC00);
    run_op("sh0_l", 0, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 32'hDEADBEEF);
    run_op("sh0_sra", 0, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    run_op("sh0_srl", 1, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF);
    run_op("sra31", 0, 32'h80000000, 5'd31, 1'b0, 1'b1, 32'hFFFFFFFF);
    run_op("sll31", 1, 32'h00000001, 5'd31, 1'b1, 1'b0, 32'h80000000);

    // contention: both valid, responses always taken
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (!req0_valid) set_req(0, 1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      if (!req1_valid) set_req(1, 1'b1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
      n = 0;
      do begin cycle(); n++; end while (hs < 0 && n < 10);
      check_val("alt_grant", W'(hs), W'(k % 2));
      if (hs >= 0) drop_req(hs);
    end
    drop_req(0); drop_req(1);
    n = 0;
    while (m_busy && n < 10) begin cycle(); n++; end

    // backpressure on resp0 with req1 waiting
    resp0_ready = 1'b0;
    set_req(0, 1'b1, 32'h12345678, 5'd8, 1'b0, 1'b0);
    n = 0;
    do begin cycle(); n++; end while (hs != 0 && n < 10);
    drop_req(0);
    set_req(1, 1'b1, 32'h0000F00D, 5'd3, 1'b1, 1'b0);
    cycle();  // EXEC
    held = resp0_data;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_val("bp_hold", resp0_data, held);
    end
    resp0_ready = 1'b1;
    cycle();  // response handshake
    cycle();  // req1 expected ready here
    check_val("bp_then_req1", W'(hs), 1);
    drop_req(1);
    n = 0;
    while (m_busy && n < 10) begin cycle(); n++; end

    // reset while in EXEC
    set_req(0, 1'b1, 32'hA5A5A5A5, 5'd1, 1'b1, 1'b0);
    n = 0;
    do begin cycle(); n++; end while (hs != 0 && n < 10);
    drop_req(0);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_val("post_rst_busy", W'(busy), 0);
    check_val("post_rst_prio", W'(dbg_prio), 0);
    check_val("post_rst_resp0", W'(resp0_valid), 0);
    run_op("after_rst", 1, 32'h0000_0F0F, 5'd4, 1'b1, 1'b0, 32'h0000_F0F0);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1)
        set_req(0, 1'b1, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom_range(0, 31)),
                1'($urandom), 1'($urandom));
      if (!req1_valid && $urandom_range(0, 1) == 1)
        set_req(1, 1'b1, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom_range(0, 31)),
                1'($urandom), 1'($urandom));
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
      if (hs >= 0) drop_req(hs);
      if (rst) begin rst = 1'b0; drop_req(0); drop_req(1); end
      else if (!m_busy && $urandom_range(0, 15) == 0) drop_req($urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer sharing one `barrel_shifter` instance between two requesters, e.g. the ALU shift path and the address/immediate formatting path of the processor datapath. Each requester issues shift operations over a valid/ready request channel and collects results over a valid/ready response channel. The block registers operands and results, so the combinational shifter is isolated from both requesters.

## Interface
Parameters:
- `WIDTH`, 32: data width; must match the shifter's 32-bit datapath.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high together with valid.
- `req0_in` / `req1_in`  in  WIDTH  operand.
- `req0_shamt` / `req1_shamt`  in  5  shift amount 0..31; zero-extended to 32 bits at the shifter.
- `req0_dir` / `req1_dir`  in  1  1 = left, 0 = right.
- `req0_aorl` / `req1_aorl`  in  1  1 = arithmetic right shift; 0 = logical. Ignored for left shifts.
- `resp0_valid` / `resp1_valid`  out  1  result available for that requester.
- `resp0_ready` / `resp1_ready`  in  1  requester takes the result.
- `resp0_data` / `resp1_data`  out  WIDTH  shifted result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states:
  - IDLE: grant one valid requester, capture `in`/`shamt`/`dir`/`aorl` and the owner ID into operand registers, then go to EXEC. Stay in IDLE if no request is valid.
  - EXEC: drive the operand registers into `barrel_shifter` and capture its `out` into the result register. Go to RESP.
  - RESP: assert `respN_valid` for the owner only. Leave for IDLE on the cycle `respN_ready` is high; otherwise hold.
- Arbitration uses a 1-bit priority pointer `prio`:
  - Only one valid requester: it is granted.
  - Both requesters valid: requester `prio` is granted.
  - After every grant, `prio` becomes the non-granted requester's index.
- `reqN_ready` is combinational: high only in IDLE, only for the requester being granted this cycle, and at most one ready is high at a time.
- Requesters hold `valid` and payload stable until the handshake. The block does not check this.
- `respN_data` holds the result register value and is stable for the whole RESP state. The non-owner's `resp_valid` stays 0.
- `shamt` = 0 returns `in` unchanged for every `dir`/`aorl` combination.
- Arithmetic right shift replicates bit 31, so `in`=0x80000000 with shamt=31 gives 0xFFFFFFFF.

## Timing
- Reset values: state IDLE, `prio`=0, `busy`=0, both `req*_ready`=0 during reset, both `resp*_valid`=0, both `resp*_data`=0, all operand and result registers 0.
- Latency: a request handshake at edge N makes `resp_valid` high at N+2, provided the block was in IDLE before edge N.
- Throughput: at best one operation per 3 cycles. The next request can handshake on the cycle after the response handshake.
- Request and response handshakes never occur in the same cycle.
- Reset mid-operation (in EXEC or RESP) aborts the operation and discards the pending result. `resp_valid` is 0 in the cycle after the reset edge, and `prio` returns to 0.
- Requester deasserts valid in IDLE without a handshake: no capture, no state change.
- Response backpressure: the block holds RESP indefinitely and asserts no `req*_ready` until the response is taken.

## Test plan
- Single left shift: after reset, req0 with in=4567, shamt=4, dir=1, aorl=0 → `req0_ready` high in the same cycle; `resp0_valid` two cycles later with `resp0_data`=73072; `resp1_valid` stays 0.
- Right shifts on req1 with in=0xFFFFFFC0 (−64), shamt=4:
  - dir=0, aorl=1 → 0xFFFFFFFC.
  - dir=0, aorl=0 → 0x0FFFFFFC.
  - dir=1, aorl=1 → 0xFFFFFC00.
- Contention: both requesters held valid continuously after reset with the response ready tied high → grants alternate req0, req1, req0, req1; a new grant every 3 cycles; each response goes to the correct requester with correct data.
- Backpressure: `resp0_ready` held low for 5 cycles with req1 valid → `resp0_valid` and `resp0_data` stay stable and `req1_ready` stays 0. On release, the response handshakes, then req1 is granted in the next cycle.
- Boundaries:
  - shamt=0 on 0xDEADBEEF → result unchanged.
  - shamt=31, dir=0, aorl=1 on 0x80000000 → 0xFFFFFFFF.
  - shamt=31, dir=1 on 0x00000001 → 0x80000000.
- Reset in EXEC: assert `rst` in EXEC → no response is issued, `busy`=0 and `prio`=0 after the reset edge. A following req1 request completes normally.
